// File: rtl/br_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : br_pc_ctrl
// Purpose  : Resolves branches and sequences the architectural PC. It decodes
//            the branch or jump type, drives the signed/unsigned select of
//            the comparator, and uses the comparator's less/equal flags,
//            which return in the same cycle, to decide taken/not-taken.
//            A taken transfer to a target that is not word aligned parks the
//            PC in a TRAP state until the handler acknowledges it. The block
//            also keeps a saturating count of retired taken transfers.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk        in   1      clock; all state changes on the rising edge
//   i_rst        in   1      synchronous active-high reset
//   i_stall      in   1      hold PC, state and counter (RUN state only)
//   i_inst_vld   in   1      current instruction is valid
//   i_is_branch  in   1      conditional branch
//   i_is_jal     in   1      JAL
//   i_is_jalr    in   1      JALR
//   i_funct3     in   3      branch condition code
//   i_br_less    in   1      comparator flag: rs1 < rs2
//   i_br_equal   in   1      comparator flag: rs1 == rs2
//   i_target     in   32     computed target address
//   i_trap_ack   in   1      trap handler acknowledge
//   o_br_un      out  1      comparator mode: 1 = signed, 0 = unsigned
//   o_pc         out  32     current PC (registered)
//   o_pc_four    out  32     o_pc + 4 (wraps at 2^32)
//   o_next_pc    out  32     PC loaded on the next accepted edge
//   o_taken      out  1      control transfer taken this cycle
//   o_misalign   out  1      high while in TRAP state
//   o_taken_cnt  out  CNT_W  saturating count of retired taken transfers
// ============================================================================
module br_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_inst_vld,
  input  logic             i_is_branch,
  input  logic             i_is_jal,
  input  logic             i_is_jalr,
  input  logic [2:0]       i_funct3,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  input  logic [31:0]      i_target,
  input  logic             i_trap_ack,
  output logic             o_br_un,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_pc_four,
  output logic [31:0]      o_next_pc,
  output logic             o_taken,
  output logic             o_misalign,
  output logic [CNT_W-1:0] o_taken_cnt
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      pc_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             cond_met;
  logic             xfer_req;
  logic [31:0]      raw_tgt;
  logic             mis;
  logic             pc_load;
  logic             cnt_inc;
  logic             cnt_sat;

  // Signed compare for BLT/BGE (funct3[1]==0), unsigned for BLTU/BGEU.
  // Depends only on funct3 so the comparator can settle within the cycle.
  assign o_br_un = ~i_funct3[1];

  // Branch condition decode; codes 010/011 are unused and never taken.
  always_comb begin
    cond_met = 1'b0;
    case (i_funct3)
      3'b000:  cond_met =  i_br_equal;
      3'b001:  cond_met = ~i_br_equal;
      3'b100:  cond_met =  i_br_less;
      3'b101:  cond_met = ~i_br_less;
      3'b110:  cond_met =  i_br_less;
      3'b111:  cond_met = ~i_br_less;
      default: cond_met = 1'b0;
    endcase
  end

  // Type priority jalr > jal > branch. Only the target formation differs
  // between jump types, so priority matters for raw_tgt alone.
  always_comb begin
    raw_tgt = i_target;
    if (i_is_jalr) begin
      raw_tgt = {i_target[31:1], 1'b0};
    end
  end

  always_comb begin
    xfer_req = 1'b0;
    if (i_is_jalr || i_is_jal) begin
      xfer_req = 1'b1;
    end else if (i_is_branch) begin
      xfer_req = cond_met;
    end
  end

  assign o_taken   = i_inst_vld & (state == RUN) & xfer_req;
  assign mis       = o_taken & (raw_tgt[1:0] != 2'b00);
  assign o_pc_four = pc_reg + 32'd4;

  always_comb begin
    o_next_pc = o_pc_four;
    if (state == TRAP) begin
      o_next_pc = i_trap_ack ? TRAP_VEC : pc_reg;
    end else if (o_taken && !mis) begin
      o_next_pc = raw_tgt;
    end
  end

  assign cnt_sat = &cnt_reg;

  // Next-state logic. In TRAP the acknowledge is honoured regardless of
  // stall; in RUN a stall freezes everything, including trap entry.
  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      RUN: begin
        if (!i_stall) begin
          if (mis) begin
            state_nxt = TRAP;
          end else begin
            pc_load = 1'b1;
            cnt_inc = o_taken & ~cnt_sat;
          end
        end
      end
      TRAP: begin
        if (i_trap_ack) begin
          state_nxt = RUN;
          pc_load   = 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= RUN;
      pc_reg  <= RESET_PC;
      cnt_reg <= '0;
    end else begin
      state <= state_nxt;
      if (pc_load) begin
        pc_reg <= o_next_pc;
      end
      if (cnt_inc) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign o_pc        = pc_reg;
  assign o_misalign  = (state == TRAP);
  assign o_taken_cnt = cnt_reg;

endmodule
`default_nettype wire

// File: tb/tb_br_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_br_pc_ctrl
// Purpose  : Self-checking bench for br_pc_ctrl. Directed scenarios followed
//            by randomized traffic compared against a behavioural model.
//            The counter is narrowed to 4 bits so saturation is reachable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_br_pc_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam int          CNT_W    = 4;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             inst_vld;
  logic             is_branch;
  logic             is_jal;
  logic             is_jalr;
  logic [2:0]       funct3;
  logic             br_less;
  logic             br_equal;
  logic [31:0]      target;
  logic             trap_ack;
  logic             br_un;
  logic [31:0]      pc;
  logic [31:0]      pc_four;
  logic [31:0]      next_pc;
  logic             taken;
  logic             misalign;
  logic [CNT_W-1:0] taken_cnt;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [31:0] m_pc;
  bit          m_trap;
  int          m_cnt;

  always #5 clk = ~clk;

  br_pc_ctrl #(
    .RESET_PC (RESET_PC),
    .TRAP_VEC (TRAP_VEC),
    .CNT_W    (CNT_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_stall     (stall),
    .i_inst_vld  (inst_vld),
    .i_is_branch (is_branch),
    .i_is_jal    (is_jal),
    .i_is_jalr   (is_jalr),
    .i_funct3    (funct3),
    .i_br_less   (br_less),
    .i_br_equal  (br_equal),
    .i_target    (target),
    .i_trap_ack  (trap_ack),
    .o_br_un     (br_un),
    .o_pc        (pc),
    .o_pc_four   (pc_four),
    .o_next_pc   (next_pc),
    .o_taken     (taken),
    .o_misalign  (misalign),
    .o_taken_cnt (taken_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Does the branch condition hold? Unused codes never take.
  function automatic bit cond_holds(input logic [2:0] f3, input bit less, input bit eq);
    case (f3)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return less;
      3'd5, 3'd7: return !less;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target();
    return is_jalr ? (target & 32'hFFFF_FFFE) : target;
  endfunction

  function automatic bit m_taken();
    bit wants;
    wants = is_jalr || is_jal || (is_branch && cond_holds(funct3, br_less, br_equal));
    return inst_vld && !m_trap && wants;
  endfunction

  function automatic bit m_mis();
    return m_taken() && (m_target() % 4 != 0);
  endfunction

  function automatic logic [31:0] m_next();
    if (m_trap)                  return trap_ack ? TRAP_VEC : m_pc;
    if (m_taken() && !m_mis())   return m_target();
    return m_pc + 32'd4;
  endfunction

  task automatic idle_inputs();
    rst = 0; stall = 0; inst_vld = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
    funct3 = 3'd0; br_less = 0; br_equal = 0; target = 32'd0; trap_ack = 0;
  endtask

  task automatic check_regs();
    check("pc", pc, m_pc);
    check("misalign", {31'd0, misalign}, {31'd0, m_trap});
    check("taken_cnt", {28'd0, taken_cnt}, m_cnt);
  endtask

  // Checks combinational outputs for the current inputs, clocks one edge,
  // advances the model, and checks the registered outputs.
  task automatic run_cycle();
    logic [31:0] nxt;
    bit          tk;
    bit          ms;
    #1;
    nxt = m_next();
    tk  = m_taken();
    ms  = m_mis();
    check("br_un", {31'd0, br_un}, {31'd0, (funct3[1] == 1'b0)});
    check("taken", {31'd0, taken}, {31'd0, tk});
    check("pc_four", pc_four, m_pc + 32'd4);
    check("next_pc", next_pc, nxt);
    @(posedge clk);
    if (rst) begin
      m_pc = RESET_PC; m_trap = 0; m_cnt = 0;
    end else if (m_trap) begin
      if (trap_ack) begin
        m_pc = TRAP_VEC; m_trap = 0;
      end
    end else if (!stall) begin
      if (ms) begin
        m_trap = 1;
      end else begin
        m_pc = nxt;
        if (tk && m_cnt < CNT_MAX) m_cnt++;
      end
    end
    #1;
    check_regs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk);
    m_pc = RESET_PC; m_trap = 0; m_cnt = 0;
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_misalign", {31'd0, misalign}, 32'd0);
    check("reset_cnt", {28'd0, taken_cnt}, 32'd0);

    // three sequential steps
    idle_inputs();
    for (int i = 0; i < 3; i++) run_cycle();
    check("seq_pc_c", pc, 32'hC);

    // BLT taken
    inst_vld = 1; is_branch = 1; funct3 = 3'b100; br_less = 1; target = 32'h40;
    #1;
    check("blt_br_un", {31'd0, br_un}, 32'd1);
    check("blt_taken", {31'd0, taken}, 32'd1);
    run_cycle();
    check("blt_pc", pc, 32'h40);
    check("blt_cnt", {28'd0, taken_cnt}, 32'd1);

    // BGEU not taken with less=1
    funct3 = 3'b111; br_less = 1; target = 32'h200;
    #1;
    check("bgeu_br_un", {31'd0, br_un}, 32'd0);
    check("bgeu_taken", {31'd0, taken}, 32'd0);
    run_cycle();
    check("bgeu_pc", pc, 32'h44);

    // JALR to 0x103 -> 0x102, misaligned
    idle_inputs();
    inst_vld = 1; is_jalr = 1; target = 32'h103;
    run_cycle();
    check("jalr_pc_held", pc, 32'h44);
    check("jalr_misalign", {31'd0, misalign}, 32'd1);
    idle_inputs();
    inst_vld = 1; is_jal = 1; target = 32'h500;
    run_cycle();
    check("trap_hold_pc", pc, 32'h44);
    idle_inputs();
    stall = 1; trap_ack = 1;
    run_cycle();
    check("ack_pc", pc, TRAP_VEC);
    check("ack_misalign", {31'd0, misalign}, 32'd0);
    check("ack_cnt", {28'd0, taken_cnt}, 32'd1);

    // BEQ under stall
    idle_inputs();
    inst_vld = 1; is_branch = 1; funct3 = 3'b000; br_equal = 1; target = 32'h80;
    stall = 1;
    run_cycle();
    run_cycle();
    check("stall_pc", pc, TRAP_VEC);
    stall = 0;
    run_cycle();
    check("beq_pc", pc, 32'h80);
    check("beq_cnt", {28'd0, taken_cnt}, 32'd2);

    // wrap
    idle_inputs();
    inst_vld = 1; is_jal = 1; target = 32'hFFFF_FFFC;
    run_cycle();
    idle_inputs();
    run_cycle();
    check("wrap_pc", pc, 32'h0);

    // reset while in TRAP
    inst_vld = 1; is_jal = 1; target = 32'h2;
    run_cycle();
    check("trap2_misalign", {31'd0, misalign}, 32'd1);
    idle_inputs();
    rst = 1;
    run_cycle();
    check("rst_trap_pc", pc, RESET_PC);
    check("rst_trap_misalign", {31'd0, misalign}, 32'd0);

    // saturation
    idle_inputs();
    inst_vld = 1; is_jal = 1;
    for (int i = 0; i < 20; i++) begin
      target = 32'h1000 + 32'(i * 8);
      run_cycle();
    end
    check("sat_cnt", {28'd0, taken_cnt}, CNT_MAX);

    // randomized traffic
    idle_inputs();
    rst = 1;
    run_cycle();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(63) == 0);
      stall     = ($urandom_range(3) == 0);
      inst_vld  = ($urandom_range(4) != 0);
      is_branch = $urandom_range(1);
      is_jal    = ($urandom_range(3) == 0);
      is_jalr   = ($urandom_range(3) == 0);
      funct3    = 3'($urandom_range(7));
      br_less   = $urandom_range(1);
      br_equal  = $urandom_range(1);
      target    = $urandom;
      if ($urandom_range(3) != 0) target[1:0] = 2'b00;
      trap_ack  = ($urandom_range(3) == 0);
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
